hpdcache_wbuf_timer_arb: RTL

Per-entry aging and send-arbitration block for the HPDcache write buffer, generalising the single write-buffer threshold counter to a parametrised array of independent counters. It tracks, for every open write-buffer directory entry, the cycles since the entry was opened or last written. It marks entries expired on a runtime-programmable threshold or on a global flush. It then round-robin arbitrates expired entries onto a valid/ready send channel toward the NoC, which can be registered or feedthrough.

---
 rtl/hpdcache_wbuf_timer_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hpdcache_wbuf_timer_arb.sv
// Write-buffer entry aging: per-entry timeout counters that mark entries expired,
// plus a round-robin arbiter offering expired entries on a valid/ready send channel.
module hpdcache_wbuf_timer_arb #(
    parameter int unsigned ENTRIES          = 16,
    parameter int unsigned TIMECNT_WIDTH    = 4,
    parameter bit          SEND_FEEDTHROUGH = 1'b0,
    parameter int unsigned IDX_W            = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i,
    input  logic                     cfg_reset_on_write_i,
    input  logic                     flush_all_i,
    input  logic [ENTRIES-1:0]       open_i,
    input  logic [ENTRIES-1:0]       write_i,
    output logic [ENTRIES-1:0]       expired_o,
    output logic                     busy_o,
    output logic                     send_valid_o,
    output logic [IDX_W-1:0]         send_entry_o,
    input  logic                     send_ready_i
);
    typedef logic [TIMECNT_WIDTH-1:0] cnt_t;
    typedef logic [IDX_W-1:0]         idx_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    function automatic idx_t wrap_inc(input idx_t v);
        return (32'(v) >= ENTRIES - 1) ? idx_t'(0) : v + idx_t'(1);
    endfunction

    cnt_t               cnt_q [ENTRIES];
    logic [ENTRIES-1:0] exp_q;
    logic [ENTRIES-1:0] sent_q;
    logic [ENTRIES-1:0] wr_rst;
    logic [ENTRIES-1:0] pend;
    logic [ENTRIES-1:0] cand;
    idx_t               rr_q;
    logic               busy_q;
    logic               grant_vld;
    idx_t               grant_idx;
    logic               hs;

    assign wr_rst    = write_i & {ENTRIES{cfg_reset_on_write_i}};
    assign pend      = exp_q & ~sent_q & open_i;
    assign hs        = send_valid_o & send_ready_i;
    assign expired_o = exp_q;
    assign busy_o    = busy_q;

    // Stage p0: per-entry age counters, sticky expiry and sent flags
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < int'(ENTRIES); e++) begin
            if (rst_i || !open_i[e]) begin
                cnt_q[e]  <= '0;
                exp_q[e]  <= 1'b0;
                sent_q[e] <= 1'b0;
            end else begin
                if (!exp_q[e]) begin
                    cnt_q[e] <= wr_rst[e] ? '0 : sat_inc(cnt_q[e]);
                end
                // flush overrides the write reset; the write reset masks the threshold
                if (flush_all_i || (!wr_rst[e] && (cnt_q[e] >= cfg_threshold_i))) begin
                    exp_q[e] <= 1'b1;
                end
                if (hs && (send_entry_o == idx_t'(e))) begin
                    sent_q[e] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= |open_i;
            if (hs) begin
                rr_q <= wrap_inc(send_entry_o);
            end
        end
    end

    // First candidate at or above the round-robin pointer, wrapping around
    always_comb begin
        int j;
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            j = int'(rr_q) + i;
            if (j >= int'(ENTRIES)) begin
                j = j - int'(ENTRIES);
            end
            if (!grant_vld && cand[idx_t'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = idx_t'(j);
            end
        end
    end

    generate
        if (SEND_FEEDTHROUGH) begin : g_ft
            assign cand         = pend;
            assign send_valid_o = grant_vld;
            assign send_entry_o = grant_idx;
        end else begin : g_reg
            logic send_vld_p1;
            idx_t send_idx_p1;

            // The entry leaving this cycle must not be offered again
            always_comb begin
                cand = pend;
                if (hs) begin
                    cand[send_idx_p1] = 1'b0;
                end
            end

            // Stage p1: offer register, held stable until accepted or its entry closes
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    send_vld_p1 <= 1'b0;
                    send_idx_p1 <= '0;
                end else if (!send_vld_p1 || hs) begin
                    send_vld_p1 <= grant_vld;
                    if (grant_vld) begin
                        send_idx_p1 <= grant_idx;
                    end
                end else if (!open_i[send_idx_p1]) begin
                    send_vld_p1 <= 1'b0;
                end
            end

            assign send_valid_o = send_vld_p1;
            assign send_entry_o = send_idx_p1;
        end
    endgenerate

endmodule
